// File: rtl/edge_detector_bank.sv
// Multi-channel glitch-filtered transition detector with per-channel Mealy edge pulse,
// sticky event flag and saturating event counter, plus a counter readback mux.
module edge_detector_bank #(
    parameter int N_CH       = 4,
    parameter int FILTER_LEN = 1,
    parameter int CNT_W      = 8,
    localparam int SEL_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  din,
    input  logic [1:0]       mode,
    input  logic [N_CH-1:0]  sticky_clr,
    input  logic             cnt_clr,
    input  logic [SEL_W-1:0] cnt_sel,
    output logic [N_CH-1:0]  edge_pulse,
    output logic [N_CH-1:0]  level,
    output logic [N_CH-1:0]  sticky,
    output logic [CNT_W-1:0] cnt_out
);

    localparam int              FC_W    = $clog2(FILTER_LEN + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {ST_INIT, ST_LOW, ST_HIGH} state_t;

    logic [CNT_W-1:0] w_cntArr [N_CH];

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            state_t           r_state;
            state_t           w_nextState;
            logic [FC_W-1:0]  r_fc;
            logic [FC_W-1:0]  w_nextFc;
            logic             r_level;
            logic             w_nextLevel;
            logic             w_rise;
            logic             w_fall;
            logic             w_pulse;
            logic             r_sticky;
            logic [CNT_W-1:0] r_cnt;

            // A differing level must persist FILTER_LEN cycles; the event fires combinationally
            // in the cycle whose clock edge accepts it.
            always_comb begin
                w_nextState = r_state;
                w_nextFc    = '0;
                w_nextLevel = r_level;
                w_rise      = 1'b0;
                w_fall      = 1'b0;
                case (r_state)
                    ST_INIT: begin
                        w_nextState = din[gi] ? ST_HIGH : ST_LOW;
                        w_nextLevel = din[gi];
                    end
                    ST_LOW: begin
                        if (din[gi]) begin
                            if (r_fc == FC_LAST) begin
                                w_nextState = ST_HIGH;
                                w_nextLevel = 1'b1;
                                w_rise      = 1'b1;
                            end else begin
                                w_nextFc = r_fc + 1'b1;
                            end
                        end
                    end
                    ST_HIGH: begin
                        if (!din[gi]) begin
                            if (r_fc == FC_LAST) begin
                                w_nextState = ST_LOW;
                                w_nextLevel = 1'b0;
                                w_fall      = 1'b1;
                            end else begin
                                w_nextFc = r_fc + 1'b1;
                            end
                        end
                    end
                    default: w_nextState = ST_INIT;
                endcase
            end

            assign w_pulse = reset & ((mode[0] & w_rise) | (mode[1] & w_fall));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state <= ST_INIT;
                    r_fc    <= '0;
                    r_level <= 1'b0;
                end else begin
                    r_state <= w_nextState;
                    r_fc    <= w_nextFc;
                    r_level <= w_nextLevel;
                end
            end

            // Set has priority over a coincident clear so no event is ever lost.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sticky <= 1'b0;
                end else if (w_pulse) begin
                    r_sticky <= 1'b1;
                end else if (sticky_clr[gi]) begin
                    r_sticky <= 1'b0;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= '0;
                end else if (cnt_clr) begin
                    r_cnt <= CNT_W'(w_pulse);
                end else if (w_pulse && (r_cnt != CNT_MAX)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign edge_pulse[gi] = w_pulse;
            assign level[gi]      = r_level;
            assign sticky[gi]     = r_sticky;
            assign w_cntArr[gi]   = r_cnt;
        end
    endgenerate

    // Out-of-range selects read as zero.
    always_comb begin
        cnt_out = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (cnt_sel == SEL_W'(k)) begin
                cnt_out = w_cntArr[k];
            end
        end
    end

endmodule

// File: tb/tb_edge_detector_bank.sv
// Bench for edge_detector_bank: dutA (FILTER_LEN=1, CNT_W=3) is checked against a scoreboard
// model; dutB (FILTER_LEN=3) is checked against hand-derived constants.
module tb_edge_detector_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] din = '0;
    logic [1:0] mode = '0;
    logic [3:0] sticky_clr = '0;
    logic       cnt_clr = 1'b0;
    logic [1:0] cnt_sel = '0;

    logic [3:0] pulseA, levelA, stickyA;
    logic [2:0] cntA;
    logic [3:0] pulseB, levelB, stickyB;
    logic [7:0] cntB;

    int nTests = 0;
    int nFail  = 0;

    // Model of dutA: accepted level, INIT flag, sticky flags and saturating counters.
    logic       mInit;
    logic [3:0] mLvl;
    logic [3:0] mSticky;
    logic [2:0] mCnt [4];

    logic [3:0]  qPulse [$];
    logic [10:0] qReg [$];

    edge_detector_bank #(.N_CH(4), .FILTER_LEN(1), .CNT_W(3)) dutA (
        .clk(clk), .reset(reset), .din(din), .mode(mode), .sticky_clr(sticky_clr),
        .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .edge_pulse(pulseA), .level(levelA),
        .sticky(stickyA), .cnt_out(cntA)
    );

    edge_detector_bank #(.N_CH(4), .FILTER_LEN(3), .CNT_W(8)) dutB (
        .clk(clk), .reset(reset), .din(din), .mode(mode), .sticky_clr(sticky_clr),
        .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .edge_pulse(pulseB), .level(levelB),
        .sticky(stickyB), .cnt_out(cntB)
    );

    always #5 clk = ~clk;

    task automatic doReset();
        @(negedge clk);
        reset = 1'b0; din = '0; mode = 2'b11; sticky_clr = '0; cnt_clr = 1'b0; cnt_sel = '0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        mInit = 1'b1; mLvl = '0; mSticky = '0;
        for (int k = 0; k < 4; k++) mCnt[k] = '0;
        qPulse.delete();
        qReg.delete();
    endtask

    // Drives one cycle of inputs on the falling edge and queues what dutA should show now.
    task automatic step(input logic [3:0] d, input logic [1:0] m, input logic [3:0] sc,
                        input logic cc, input logic [1:0] sel);
        logic [3:0] p;
        @(negedge clk);
        din = d; mode = m; sticky_clr = sc; cnt_clr = cc; cnt_sel = sel;
        p = mInit ? 4'b0000 : (((~mLvl & d) & {4{m[0]}}) | ((mLvl & ~d) & {4{m[1]}}));
        qPulse.push_back(p);
        qReg.push_back({mLvl, mSticky, mCnt[sel]});
        for (int k = 0; k < 4; k++) begin
            if (cc) mCnt[k] = p[k] ? 3'd1 : 3'd0;
            else if (p[k] && mCnt[k] != 3'd7) mCnt[k] = mCnt[k] + 3'd1;
        end
        mSticky = p | (mSticky & ~sc);
        mLvl  = d;
        mInit = 1'b0;
        #2;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; din = 4'hF; mode = 2'b11; cnt_sel = 2'd3;
        #2;
        nTests += 2;
        if ({pulseA, levelA, stickyA, cntA} !== 15'd0) begin
            nFail++;
            $display("[TB] FAIL reset_A: got %h want 0", {pulseA, levelA, stickyA, cntA});
        end
        if ({pulseB, levelB, stickyB, cntB} !== 20'd0) begin
            nFail++;
            $display("[TB] FAIL reset_B: got %h want 0", {pulseB, levelB, stickyB, cntB});
        end
    endtask

    task automatic test_rise_fall();
        logic [3:0]  ep;
        logic [10:0] er;
        int seen = 0;
        doReset();
        for (int s = 0; s < 33; s++) begin
            step((s >= 1 && s <= 30) ? 4'b0001 : 4'b0000, 2'b11, 4'b0000, 1'b0, 2'd0);
            ep = qPulse.pop_front();
            er = qReg.pop_front();
            if (pulseA[0]) seen++;
            nTests += 2;
            if (pulseA !== ep) begin
                nFail++;
                $display("[TB] FAIL rf_pulse s=%0d: got %b want %b", s, pulseA, ep);
            end
            if ({levelA, stickyA, cntA} !== er) begin
                nFail++;
                $display("[TB] FAIL rf_regs s=%0d: got %h want %h", s, {levelA, stickyA, cntA}, er);
            end
        end
        nTests += 3;
        if (seen != 2) begin
            nFail++;
            $display("[TB] FAIL rf_pulse_count: got %0d want 2", seen);
        end
        if (cntA !== 3'd2) begin
            nFail++;
            $display("[TB] FAIL rf_cnt: got %0d want 2", cntA);
        end
        if (stickyA[0] !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL rf_sticky: got %b want 1", stickyA[0]);
        end
    endtask

    task automatic test_filter();
        logic [3:0] dSeq  [8] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2};
        logic [3:0] pExp  [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
        logic [3:0] lExp  [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
        logic [7:0] cExp  [8] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        doReset();
        for (int s = 0; s < 8; s++) begin
            step(dSeq[s], 2'b01, 4'b0000, 1'b0, 2'd1);
            nTests += 3;
            if (pulseB !== pExp[s]) begin
                nFail++;
                $display("[TB] FAIL filt_pulse s=%0d: got %b want %b", s, pulseB, pExp[s]);
            end
            if (levelB !== lExp[s]) begin
                nFail++;
                $display("[TB] FAIL filt_level s=%0d: got %b want %b", s, levelB, lExp[s]);
            end
            if (cntB !== cExp[s]) begin
                nFail++;
                $display("[TB] FAIL filt_cnt s=%0d: got %0d want %0d", s, cntB, cExp[s]);
            end
        end
    endtask

    task automatic test_mode();
        logic [3:0]  dSeq [8] = '{4'h0, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0};
        logic [1:0]  mSeq [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        logic [3:0]  ep;
        logic [10:0] er;
        doReset();
        for (int s = 0; s < 8; s++) begin
            step(dSeq[s], mSeq[s], 4'b0000, 1'b0, 2'd2);
            ep = qPulse.pop_front();
            er = qReg.pop_front();
            nTests += 2;
            if (pulseA !== ep) begin
                nFail++;
                $display("[TB] FAIL mode_pulse s=%0d: got %b want %b", s, pulseA, ep);
            end
            if ({levelA, stickyA, cntA} !== er) begin
                nFail++;
                $display("[TB] FAIL mode_regs s=%0d: got %h want %h", s, {levelA, stickyA, cntA}, er);
            end
        end
    endtask

    task automatic test_saturate();
        logic [3:0]  ep;
        logic [10:0] er;
        doReset();
        step(4'h0, 2'b01, 4'b0000, 1'b0, 2'd3);
        void'(qPulse.pop_front());
        void'(qReg.pop_front());
        for (int s = 0; s < 20; s++) begin
            step((s % 2 == 0) ? 4'h8 : 4'h0, 2'b01, 4'b0000, (s == 18), 2'd3);
            ep = qPulse.pop_front();
            er = qReg.pop_front();
            nTests += 2;
            if (pulseA !== ep) begin
                nFail++;
                $display("[TB] FAIL sat_pulse s=%0d: got %b want %b", s, pulseA, ep);
            end
            if ({levelA, stickyA, cntA} !== er) begin
                nFail++;
                $display("[TB] FAIL sat_regs s=%0d: got %h want %h", s, {levelA, stickyA, cntA}, er);
            end
            if (s == 17) begin
                nTests++;
                if (cntA !== 3'd7) begin
                    nFail++;
                    $display("[TB] FAIL sat_max: got %0d want 7", cntA);
                end
            end
            if (s == 19) begin
                nTests++;
                if (cntA !== 3'd1) begin
                    nFail++;
                    $display("[TB] FAIL sat_clr_with_edge: got %0d want 1", cntA);
                end
            end
        end
    endtask

    task automatic test_sticky();
        logic [3:0] dSeq [4] = '{4'h0, 4'h1, 4'h1, 4'h1};
        logic [3:0] cSeq [4] = '{4'h0, 4'h1, 4'h1, 4'h0};
        logic [3:0] sExp [4] = '{4'h0, 4'h0, 4'h1, 4'h0};
        doReset();
        for (int s = 0; s < 4; s++) begin
            step(dSeq[s], 2'b11, cSeq[s], 1'b0, 2'd0);
            void'(qPulse.pop_front());
            void'(qReg.pop_front());
            nTests++;
            if (stickyA !== sExp[s]) begin
                nFail++;
                $display("[TB] FAIL sticky s=%0d: got %b want %b", s, stickyA, sExp[s]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  dSeq [5] = '{4'h0, 4'hF, 4'h0, 4'hF, 4'h0};
        logic [3:0]  ep;
        logic [10:0] er;
        doReset();
        for (int s = 0; s < 9; s++) begin
            step((s < 5) ? dSeq[s] : 4'h0, 2'b11, 4'b0000, 1'b0, (s < 5) ? 2'd0 : 2'(s - 5));
            ep = qPulse.pop_front();
            er = qReg.pop_front();
            nTests += 2;
            if (pulseA !== ep) begin
                nFail++;
                $display("[TB] FAIL b2b_pulse s=%0d: got %b want %b", s, pulseA, ep);
            end
            if ({levelA, stickyA, cntA} !== er) begin
                nFail++;
                $display("[TB] FAIL b2b_regs s=%0d: got %h want %h", s, {levelA, stickyA, cntA}, er);
            end
            if (s >= 5) begin
                nTests++;
                if (cntA !== 3'd4) begin
                    nFail++;
                    $display("[TB] FAIL b2b_cnt sel=%0d: got %0d want 4", s - 5, cntA);
                end
            end
        end
    endtask

    task automatic test_reset_mid_filter();
        doReset();
        step(4'h0, 2'b01, 4'b0000, 1'b0, 2'd0);
        step(4'h1, 2'b01, 4'b0000, 1'b0, 2'd0);
        step(4'h1, 2'b01, 4'b0000, 1'b0, 2'd0);
        @(negedge clk);
        din = 4'h1;
        reset = 1'b0;
        #2;
        nTests++;
        if ({pulseB, levelB, stickyB, cntB} !== 20'd0) begin
            nFail++;
            $display("[TB] FAIL rst_mid: got %h want 0", {pulseB, levelB, stickyB, cntB});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        step(4'h1, 2'b01, 4'b0000, 1'b0, 2'd0);
        nTests++;
        if (pulseB !== 4'h0) begin
            nFail++;
            $display("[TB] FAIL rst_init_pulse: got %b want 0000", pulseB);
        end
        step(4'h1, 2'b01, 4'b0000, 1'b0, 2'd0);
        nTests++;
        if ({pulseB, levelB, stickyB, cntB} !== {4'h0, 4'h1, 4'h0, 8'd0}) begin
            nFail++;
            $display("[TB] FAIL rst_init_exit: got %h want %h",
                     {pulseB, levelB, stickyB, cntB}, {4'h0, 4'h1, 4'h0, 8'd0});
        end
    endtask

    initial begin
        test_reset();
        test_rise_fall();
        test_filter();
        test_mode();
        test_saturate();
        test_sticky();
        test_back_to_back();
        test_reset_mid_filter();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
